uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with an input FIFO and valid/ready intake.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and parameter checks for the TX path (and the future RX path).
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_OFF  = 2'b11
  } parity_t;

  function automatic bit bit_period_ok(input int clk_div);
    return clk_div >= 2;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 and pulses bit_tick on the last count.
// restart holds the count at zero so the next bit period starts cleanly.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (restart || bit_tick) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and valid/ready intake; frames go out LSB first.
// Define UART_TX_PARITY_EN to add the parity_mode port and the PARITY state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_data,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                      parity_mode,
`endif
  output logic                            tx_line,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(DATA_W);

  if (!bit_period_ok(CLK_DIV)) begin : g_bad_div
    $error("uart_tx_fifo: CLK_DIV must be >= 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("uart_tx_fifo: DATA_W must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;

  uart_tx_state_t    state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              par_en, par_bit;

  logic              bit_tick, restart, push, pop, fifo_empty, stop_last;
  logic [DATA_W-1:0] head;
  logic              load_par_en, load_par_bit;

  assign fifo_empty = (count == '0);
  assign s_ready    = (count != LVL_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign stop_last  = (stop_cnt == 1'(STOP_BITS - 1));
  // Pop either from idle or on the last stop tick, so back-to-back frames have no gap.
  assign pop        = !fifo_empty &&
                      ((state == IDLE) || (state == STOP && bit_tick && stop_last));
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;
  assign fifo_level = count;
  assign restart    = (state == IDLE);

`ifdef UART_TX_PARITY_EN
  parity_t mode;
  assign mode         = parity_t'(parity_mode);
  assign load_par_en  = (mode == PAR_EVEN) || (mode == PAR_ODD);
  assign load_par_bit = (mode == PAR_ODD) ? ~^head : ^head;
`else
  assign load_par_en  = 1'b0;
  assign load_par_bit = 1'b0;
`endif

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_line  <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      // Parity settings are captured with the word; later mode changes wait for the next pop.
      state   <= START;
      tx_line <= 1'b0;
      shreg   <= head;
      par_en  <= load_par_en;
      par_bit <= load_par_bit;
    end else if (bit_tick) begin
      case (state)
        START: begin
          tx_line <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            if (par_en) begin
              tx_line <= par_bit;
              state   <= PARITY;
            end else begin
              tx_line  <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end else begin
            tx_line <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          tx_line  <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= STOP;
        end
        STOP: begin
          if (stop_last) state    <= IDLE;
          else           stop_cnt <= stop_cnt + 1'b1;
        end
        default: begin
          tx_line <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level model with per-cycle compare plus literal frame checks.
module tb_uart_tx_fifo;

  localparam int CD    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic [1:0] pmode = 2'b00;
  logic       s_ready, tx_line, busy;
  logic [2:0] fifo_level;

  logic       v2 = 1'b0;
  logic [6:0] d2 = '0;
  logic       rdy2, tx2, busy2;
  logic [2:0] lvl2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_W(DW), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pmode),
`endif
    .tx_line    (tx_line),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_W(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (v2),
    .s_ready    (rdy2),
    .s_data     (d2),
`ifdef UART_TX_PARITY_EN
    .parity_mode(2'b00),
`endif
    .tx_line    (tx2),
    .busy       (busy2),
    .fifo_level (lvl2)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of words and the bit list of the frame on the wire.
  logic [7:0] mq[$];
  logic       fb[16];
  int         flen = 0;
  int         pos = 0;
  bit         active = 0;
  bit         m_acc;
  logic [7:0] m_w;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      active = 0;
      pos = 0;
    end else begin
      m_acc = s_valid && (mq.size() != DEPTH);
      if (active) begin
        pos++;
        if (pos == flen * CD) active = 0;
      end
      if (!active && mq.size() > 0) begin
        m_w = mq.pop_front();
        fb[0] = 1'b0;
        for (int i = 0; i < DW; i++) fb[1+i] = m_w[i];
        flen = 1 + DW;
`ifdef UART_TX_PARITY_EN
        if (pmode == 2'b01 || pmode == 2'b10) begin
          fb[flen] = (pmode == 2'b01) ? ^m_w : ~^m_w;
          flen++;
        end
`endif
        fb[flen] = 1'b1;
        flen++;
        active = 1;
        pos = 0;
      end
      if (m_acc) mq.push_back(s_data);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("tx_line", int'(tx_line), active ? int'(fb[pos/CD]) : 1);
      chk("busy", int'(busy), int'(active || mq.size() > 0));
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("s_ready", int'(s_ready), int'(mq.size() != DEPTH));
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input logic [7:0] d, output int waits);
    s_valid = 1'b1;
    s_data  = d;
    waits   = 0;
    while (!s_ready && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    if (!s_ready) begin
      chk("push_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Samples each bit mid-period from the first start bit and counts busy cycles from there.
  task automatic capture(input int nbits, output logic [31:0] bits, output int len);
    int k;
    bits = '0;
    len  = 0;
    k    = 0;
    while (tx_line !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (tx_line !== 1'b0) begin
      chk("start_timeout", 0, 1);
      return;
    end
    k = 0;
    while (busy && k < 500) begin
      if (k % CD == CD / 2 && k / CD < nbits) bits[k/CD] = tx_line;
      @(negedge clk);
      k++;
    end
    len = k;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int          w, len, k;
    logic [31:0] bits;

    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx_line), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, no parity: 0,1,0,1,0,0,1,0,1,1 in time order.
    push(8'hA5, w);
    capture(10, bits, len);
    chk("a5_bits", int'(bits[9:0]), 'h34A);
    chk("a5_len", len, 40);
    chk("a5_busy_after", int'(busy), 0);

    // Back-to-back frames: stop of 00 is immediately followed by start of FF.
    push(8'h00, w);
    push(8'hFF, w);
    capture(20, bits, len);
    chk("b2b_bits", int'(bits[19:0]), 'hFFA00);
    chk("b2b_len", len, 80);

    // First word goes straight to the shifter, the next four fill the FIFO.
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), w);
    chk("full_ready", int'(s_ready), 0);
    chk("full_level", int'(fifo_level), 4);
    push(8'h3C, w);
    chk("held_until_pop", int'(w > 30), 1);
    wait_idle(400);

`ifdef UART_TX_PARITY_EN
    pmode = 2'b01;
    push(8'h07, w);
    capture(11, bits, len);
    chk("even_par_bit", int'(bits[9]), 1);
    chk("even_len", len, 44);

    pmode = 2'b10;
    push(8'h07, w);
    fork
      capture(11, bits, len);
      begin
        repeat (8) @(negedge clk);
        pmode = 2'b11;
      end
    join
    chk("odd_par_bit", int'(bits[9]), 0);
    chk("odd_len", len, 44);

    push(8'h07, w);
    capture(10, bits, len);
    chk("none_len", len, 40);
    pmode = 2'b00;
`endif

    // DATA_W=7, STOP_BITS=2: 0, 1010101 LSB first, then two stop bits.
    v2 = 1'b1;
    d2 = 7'h55;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    k = 0;
    while (tx2 !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("w7_start_seen", int'(tx2), 0);
    k = 0;
    bits = '0;
    while (busy2 && k < 200) begin
      if (k % CD == CD / 2 && k / CD < 16) bits[k/CD] = tx2;
      @(negedge clk);
      k++;
    end
    chk("w7_bits", int'(bits[9:0]), 'h3AA);
    chk("w7_len", k, 40);
    chk("w7_idle_line", int'(tx2), 1);

    // Asynchronous reset in the middle of a frame with words still queued.
    push(8'h5A, w);
    push(8'hC3, w);
    push(8'h81, w);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx_line), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_ready", int'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push(8'h3E, w);
    capture(10, bits, len);
    chk("post_rst_bits", int'(bits[9:0]), 'h27C);
    chk("post_rst_len", len, 40);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
